// File: rtl/uart_prog_loader.sv
// uart_prog_loader
//   Boot-time program loader. Receives a framed binary image over a UART RX
//   pin (8N1, LSB first, idle high) and writes it byte-by-byte into program
//   memory. The CPU stays held in reset until a checksum-verified image has
//   been written.
//
//   Frame: 0xA5, LEN_H, LEN_L, N data bytes (N = {LEN_H,LEN_L}), CHK
//          CHK = 8-bit sum of the data bytes (mod 256)
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   rx          UART serial input
//   mem_addr    memory write address (BASE_ADDR at frame start, wraps)
//   mem_wdata   memory write data
//   mem_we      single-cycle memory write strobe, one per data byte
//   cpu_hold    1 = keep pc/control unit in reset
//   load_done   1 after a successful load, until the next frame start
//   load_err    sticky error flag, cleared at the next frame start
//   byte_count  data bytes written in the current/last frame
//
// Internal handshake: rx_valid/rx_byte is a one-cycle valid pulse with no
// ready; the frame FSM accepts every byte on the cycle it is presented, and
// rx_byte is held stable until the next pulse. rx_ferr is a one-cycle pulse
// for a byte whose stop bit sampled low; such a byte is never presented.

module uart_prog_loader #(
  parameter int          CLKS_PER_BIT = 234,
  parameter logic [15:0] BASE_ADDR    = 16'h0000,
  parameter int          TIMEOUT_CLKS = 2700000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err,
  output logic [15:0] byte_count
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]       SYNC_BYTE = 8'hA5;

  // ------------------------------------------------------------------
  // RX synchronizer and falling-edge detect
  // ------------------------------------------------------------------
  logic rx_meta, rx_sync, rx_sync_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_sync_d <= 1'b1;
    end else begin
      rx_meta   <= rx;
      rx_sync   <= rx_meta;
      rx_sync_d <= rx_sync;
    end
  end

  // Edge (not level) detect so a low stop bit cannot look like a new start.
  logic rx_fall;
  assign rx_fall = rx_sync_d & ~rx_sync;

  // ------------------------------------------------------------------
  // RX engine
  // ------------------------------------------------------------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t        rx_state, rx_state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic [7:0]       rx_byte;
  logic             rx_valid;
  logic             rx_ferr;
  logic             bit_tick;

  // The start bit is checked half a bit in; every later sample is one full
  // bit period after the previous, so all samples land mid-bit.
  always_comb begin
    bit_tick     = (rx_state == RX_START) ? (bit_cnt == HALF_LAST)
                                          : (bit_cnt == BIT_LAST);
    rx_state_nxt = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_state_nxt = RX_START;
      RX_START: if (bit_tick) rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_tick && bit_idx == 3'd7) rx_state_nxt = RX_STOP;
      RX_STOP:  if (bit_tick) rx_state_nxt = RX_IDLE;
      default:  rx_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state  <= RX_IDLE;
      bit_cnt   <= '0;
      bit_idx   <= 3'd0;
      shift_reg <= 8'h00;
      rx_byte   <= 8'h00;
      rx_valid  <= 1'b0;
      rx_ferr   <= 1'b0;
    end else begin
      rx_state <= rx_state_nxt;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      if (rx_state == RX_IDLE || bit_tick) bit_cnt <= '0;
      else                                 bit_cnt <= bit_cnt + 1'b1;
      if (rx_state == RX_START && bit_tick) bit_idx <= 3'd0;
      if (rx_state == RX_DATA && bit_tick) begin
        shift_reg <= {rx_sync, shift_reg[7:1]};
        bit_idx   <= bit_idx + 3'd1;
      end
      if (rx_state == RX_STOP && bit_tick) begin
        if (rx_sync) begin
          rx_valid <= 1'b1;
          rx_byte  <= shift_reg;
        end else begin
          rx_ferr  <= 1'b1;
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Frame FSM
  // ------------------------------------------------------------------
  typedef enum logic [2:0] {
    F_IDLE, F_LEN_H, F_LEN_L, F_DATA, F_CHK, F_DONE
  } frame_state_t;

  frame_state_t     frame_state, frame_state_nxt;
  logic [15:0]      len;
  logic [7:0]       sum;
  logic [TMO_W-1:0] tmo_cnt;
  logic             in_frame;
  logic             start_frame;
  logic             tmo_hit;
  logic             abort;
  logic             wr_last;

  always_comb begin
    in_frame    = (frame_state == F_LEN_H) || (frame_state == F_LEN_L) ||
                  (frame_state == F_DATA)  || (frame_state == F_CHK);
    start_frame = ((frame_state == F_IDLE) || (frame_state == F_DONE)) &&
                  rx_valid && (rx_byte == SYNC_BYTE);
    // A byte arriving on the same cycle as the limit keeps the frame alive.
    tmo_hit     = in_frame && !rx_valid && (tmo_cnt == TMO_LAST);
    abort       = in_frame && (rx_ferr || tmo_hit);
    // The move to CHK waits for the last write strobe so mem_we is only
    // ever high while the FSM sits in DATA.
    wr_last     = mem_we && ((byte_count + 16'd1) == len);

    frame_state_nxt = frame_state;
    case (frame_state)
      F_IDLE, F_DONE: if (start_frame) frame_state_nxt = F_LEN_H;
      F_LEN_H: if (rx_valid) frame_state_nxt = F_LEN_L;
      F_LEN_L: if (rx_valid)
                 frame_state_nxt = ({len[15:8], rx_byte} == 16'h0000) ? F_CHK : F_DATA;
      F_DATA:  if (wr_last) frame_state_nxt = F_CHK;
      F_CHK:   if (rx_valid)
                 frame_state_nxt = (rx_byte == sum) ? F_DONE : F_IDLE;
      default: frame_state_nxt = F_IDLE;
    endcase
    if (abort) frame_state_nxt = F_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_state <= F_IDLE;
      len         <= 16'h0000;
      sum         <= 8'h00;
      tmo_cnt     <= '0;
      mem_addr    <= BASE_ADDR;
      mem_wdata   <= 8'h00;
      mem_we      <= 1'b0;
      cpu_hold    <= 1'b1;
      load_done   <= 1'b0;
      load_err    <= 1'b0;
      byte_count  <= 16'h0000;
    end else begin
      frame_state <= frame_state_nxt;
      mem_we      <= 1'b0;

      if (!in_frame || rx_valid) tmo_cnt <= '0;
      else if (!tmo_hit)         tmo_cnt <= tmo_cnt + 1'b1;

      if (start_frame) begin
        cpu_hold   <= 1'b1;
        load_done  <= 1'b0;
        load_err   <= 1'b0;
        byte_count <= 16'h0000;
        sum        <= 8'h00;
        mem_addr   <= BASE_ADDR;
      end

      if (frame_state == F_LEN_H && rx_valid) len[15:8] <= rx_byte;
      if (frame_state == F_LEN_L && rx_valid) len[7:0]  <= rx_byte;

      if (frame_state == F_DATA && rx_valid) begin
        mem_wdata <= rx_byte;
        mem_we    <= 1'b1;
        sum       <= sum + rx_byte;
      end

      // Address and count advance on the cycle after the strobe.
      if (frame_state == F_DATA && mem_we) begin
        mem_addr   <= mem_addr + 16'd1;
        byte_count <= byte_count + 16'd1;
      end

      if (frame_state == F_CHK && rx_valid) begin
        if (rx_byte == sum) begin
          load_done <= 1'b1;
          cpu_hold  <= 1'b0;
        end else begin
          load_err  <= 1'b1;
        end
      end

      if (abort) load_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb_uart_prog_loader
//   Directed + randomized bench for uart_prog_loader. Two instances: dut_a
//   (BASE_ADDR 0000) carries most traffic, dut_b (BASE_ADDR FFFE) shows the
//   address wrap. A frame-level parser model derives expected writes/status
//   from the transmitted byte list.

module tb_uart_prog_loader;

  localparam int CPB = 4;
  localparam int TMO = 100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_a = 1'b1;
  logic rx_b = 1'b1;

  always #5 clk = ~clk;

  logic [15:0] mem_addr_a, mem_addr_b, byte_count_a, byte_count_b;
  logic [7:0]  mem_wdata_a, mem_wdata_b;
  logic        mem_we_a, mem_we_b, cpu_hold_a, cpu_hold_b;
  logic        load_done_a, load_done_b, load_err_a, load_err_b;

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(16'h0000), .TIMEOUT_CLKS(TMO)) dut_a (
    .clk(clk), .rst_n(rst_n), .rx(rx_a),
    .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_we(mem_we_a),
    .cpu_hold(cpu_hold_a), .load_done(load_done_a), .load_err(load_err_a),
    .byte_count(byte_count_a)
  );

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(16'hFFFE), .TIMEOUT_CLKS(TMO)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx(rx_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_we(mem_we_b),
    .cpu_hold(cpu_hold_b), .load_done(load_done_b), .load_err(load_err_b),
    .byte_count(byte_count_b)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];
  logic [23:0] obs_a[$];
  logic [23:0] obs_b[$];
  logic [7:0]  tx_q[$];
  logic        exp_done, exp_err;
  logic [15:0] exp_cnt;

  // Every strobe seen at a falling edge is one write; a strobe that stays
  // high for two cycles shows up as a duplicate write.
  always @(negedge clk) begin
    if (mem_we_a) obs_a.push_back({mem_addr_a, mem_wdata_a});
    if (mem_we_b) obs_b.push_back({mem_addr_b, mem_wdata_b});
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish (errors=%0d checks=%0d)", errors, checks);
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input int which, input string tag, input logic done,
                              input logic err, input logic [15:0] cnt, input logic [15:0] addr);
    if (which == 0) begin
      check({tag, " load_done"}, 32'(load_done_a), 32'(done));
      check({tag, " load_err"},  32'(load_err_a),  32'(err));
      check({tag, " cpu_hold"},  32'(cpu_hold_a),  32'(!done));
      check({tag, " byte_count"}, 32'(byte_count_a), 32'(cnt));
      check({tag, " mem_addr"},  32'(mem_addr_a),  32'(addr));
    end else begin
      check({tag, " load_done"}, 32'(load_done_b), 32'(done));
      check({tag, " load_err"},  32'(load_err_b),  32'(err));
      check({tag, " cpu_hold"},  32'(cpu_hold_b),  32'(!done));
      check({tag, " byte_count"}, 32'(byte_count_b), 32'(cnt));
      check({tag, " mem_addr"},  32'(mem_addr_b),  32'(addr));
    end
  endtask

  // Compare observed writes of one DUT against exp_q, then clear both.
  task automatic compare_writes(input int which, input string tag);
    logic [23:0] obs[$];
    int n;
    obs = (which == 0) ? obs_a : obs_b;
    check({tag, " write count"}, 32'(obs.size()), 32'(exp_q.size()));
    n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s write[%0d] addr/data", tag, i), 32'(obs[i]), 32'(exp_q[i]));
    exp_q.delete();
    if (which == 0) obs_a.delete(); else obs_b.delete();
  endtask

  // ---------------- reference model ----------------
  // Parses tx_q as [ignored bytes] A5 LEN_H LEN_L data... CHK.
  task automatic model_frame(input logic [15:0] base);
    int i;
    int n;
    int total;
    logic [7:0] chk;
    i = 0;
    while (i < tx_q.size() && tx_q[i] != 8'hA5) i++;
    n = {24'h0, tx_q[i+1], tx_q[i+2]};
    total = 0;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({base + 16'(k), tx_q[i+3+k]});
      total += int'(tx_q[i+3+k]);
    end
    chk      = tx_q[i+3+n];
    exp_done = (int'(chk) == (total % 256));
    exp_err  = !exp_done;
    exp_cnt  = 16'(n);
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input int which, input logic v);
    if (which == 0) rx_a = v; else rx_b = v;
  endtask

  // Called on a falling edge; each bit lasts CPB clocks.
  task automatic send_byte(input int which, input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      drive(which, bits[i]);
      repeat (CPB) @(negedge clk);
    end
    drive(which, 1'b1);
  endtask

  task automatic send_q(input int which);
    foreach (tx_q[i]) send_byte(which, tx_q[i], 1'b1);
    repeat (6) @(negedge clk);
  endtask

  function automatic logic [7:0] rand_non_sync();
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    if (b == 8'hA5) b = 8'h00;
    return b;
  endfunction

  // Random frame into tx_q: leading noise, random payload, optional bad CHK.
  task automatic build_random_frame(input int len, input bit good);
    int total;
    int ng;
    logic [7:0] d;
    tx_q.delete();
    ng = $urandom_range(0, 2);
    for (int i = 0; i < ng; i++) tx_q.push_back(rand_non_sync());
    tx_q.push_back(8'hA5);
    tx_q.push_back(8'(len >> 8));
    tx_q.push_back(8'(len));
    total = 0;
    for (int i = 0; i < len; i++) begin
      d = 8'($urandom_range(0, 255));
      tx_q.push_back(d);
      total += int'(d);
    end
    if (good) tx_q.push_back(8'(total % 256));
    else      tx_q.push_back(8'((total % 256) + $urandom_range(1, 255)));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset values
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst a mem_addr", 32'(mem_addr_a), 32'h0000);
    check("rst b mem_addr", 32'(mem_addr_b), 32'hFFFE);
    check("rst a mem_wdata", 32'(mem_wdata_a), 32'h0);
    check("rst a mem_we", 32'(mem_we_a), 32'h0);
    check("rst b mem_we", 32'(mem_we_b), 32'h0);
    check_status(0, "rst a", 1'b0, 1'b0, 16'h0, 16'h0000);
    check_status(1, "rst b", 1'b0, 1'b0, 16'h0, 16'hFFFE);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // One-cycle glitch in IDLE: no byte, no error
    rx_a = 1'b0;
    @(negedge clk);
    rx_a = 1'b1;
    repeat (60) @(negedge clk);
    compare_writes(0, "glitch");
    check_status(0, "glitch", 1'b0, 1'b0, 16'h0, 16'h0000);

    // Basic three-byte frame
    tx_q = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
    send_q(0);
    model_frame(16'h0000);
    compare_writes(0, "basic");
    check_status(0, "basic", exp_done, exp_err, exp_cnt, 16'h0003);

    // Bad checksum, then a valid random frame
    tx_q = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h67};
    send_q(0);
    model_frame(16'h0000);
    compare_writes(0, "badchk");
    check_status(0, "badchk", exp_done, exp_err, exp_cnt, 16'h0003);
    build_random_frame(3, 1'b1);
    send_q(0);
    model_frame(16'h0000);
    compare_writes(0, "recover");
    check_status(0, "recover", exp_done, exp_err, exp_cnt, 16'h0003);

    // Leading noise then an empty image
    tx_q = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h00, 8'h00};
    send_q(0);
    model_frame(16'h0000);
    compare_writes(0, "empty");
    check_status(0, "empty", exp_done, exp_err, exp_cnt, 16'h0000);

    // Address wrap on dut_b
    build_random_frame(4, 1'b1);
    send_q(1);
    model_frame(16'hFFFE);
    compare_writes(1, "wrap");
    check_status(1, "wrap", exp_done, exp_err, exp_cnt, 16'h0002);

    // Stop bit low on second data byte
    send_byte(0, 8'hA5, 1'b1);
    send_byte(0, 8'h00, 1'b1);
    send_byte(0, 8'h03, 1'b1);
    send_byte(0, 8'h11, 1'b1);
    send_byte(0, 8'h22, 1'b0);
    repeat (8) @(negedge clk);
    exp_q.push_back({16'h0000, 8'h11});
    compare_writes(0, "stopbit");
    check_status(0, "stopbit", 1'b0, 1'b1, 16'h0001, 16'h0001);
    // FSM must now be idle: a stray data byte writes nothing, error sticks
    send_byte(0, 8'h33, 1'b1);
    repeat (8) @(negedge clk);
    compare_writes(0, "stopbit idle");
    check_status(0, "stopbit idle", 1'b0, 1'b1, 16'h0001, 16'h0001);

    // Inter-byte timeout
    send_byte(0, 8'hA5, 1'b1);
    send_byte(0, 8'h00, 1'b1);
    send_byte(0, 8'h02, 1'b1);
    send_byte(0, 8'h11, 1'b1);
    repeat (TMO - 15) @(negedge clk);
    check("tmo before limit load_err", 32'(load_err_a), 32'h0);
    repeat (30) @(negedge clk);
    exp_q.push_back({16'h0000, 8'h11});
    compare_writes(0, "tmo");
    check_status(0, "tmo", 1'b0, 1'b1, 16'h0001, 16'h0001);

    // Randomized frames, mostly good checksums
    for (int r = 0; r < 4; r++) begin
      int len;
      bit good;
      len  = $urandom_range(1, 6);
      good = ($urandom_range(0, 3) != 0);
      build_random_frame(len, good);
      send_q(0);
      model_frame(16'h0000);
      compare_writes(0, $sformatf("rand%0d", r));
      check_status(0, $sformatf("rand%0d", r), exp_done, exp_err, exp_cnt, 16'(len));
    end

    // Reset mid-DATA: outputs return to reset values without a clock edge
    send_byte(0, 8'hA5, 1'b1);
    send_byte(0, 8'h00, 1'b1);
    send_byte(0, 8'h04, 1'b1);
    send_byte(0, 8'h01, 1'b1);
    send_byte(0, 8'h02, 1'b1);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst mem_addr", 32'(mem_addr_a), 32'h0000);
    check("async rst mem_wdata", 32'(mem_wdata_a), 32'h0);
    check("async rst mem_we", 32'(mem_we_a), 32'h0);
    check_status(0, "async rst", 1'b0, 1'b0, 16'h0, 16'h0000);
    exp_q.push_back({16'h0000, 8'h01});
    exp_q.push_back({16'h0001, 8'h02});
    compare_writes(0, "partial");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    build_random_frame(2, 1'b1);
    send_q(0);
    model_frame(16'h0000);
    compare_writes(0, "after rst");
    check_status(0, "after rst", exp_done, exp_err, exp_cnt, 16'h0002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Boot-time program loader upstream of the CPU memory: receives a framed binary image over a UART RX pin and writes it byte-by-byte into program memory.
- Holds the CPU (pc/control unit) in reset until a checksum-verified image has been written.
- Sits between the board RX pin and the memory write port; muxed onto the memory address/data lines while cpu_hold is high.

Parameters:
CLKS_PER_BIT, 234, clk cycles per UART bit (27 MHz / 115200); minimum 4
BASE_ADDR, 16'h0000, memory address of first image byte
TIMEOUT_CLKS, 2700000, max idle clk cycles between bytes inside a frame before abort

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
rx  input  1  UART serial input, idle high, 8N1, LSB first
mem_addr  output  16  memory write address
mem_wdata  output  8  memory write data
mem_we  output  1  single-cycle memory write strobe
cpu_hold  output  1  high = keep pc/control unit in reset
load_done  output  1  high after successful load, until next frame start
load_err  output  1  sticky error flag, cleared at next frame start
byte_count  output  16  data bytes written in current/last frame

Behaviour:
- Single clock domain, all outputs registered. rst_n asynchronous, active-low: everything reset immediately on assertion.
- Reset values:
  - mem_addr=BASE_ADDR, mem_wdata=0, mem_we=0
  - cpu_hold=1, load_done=0, load_err=0, byte_count=0
  - FSM in IDLE, RX engine idle.
- RX engine:
  - rx passes through a 2-FF synchronizer, reset value 1.
  - Falling edge starts a bit counter. At CLKS_PER_BIT/2 the start bit is re-sampled; if high, it is a glitch and the engine returns to idle with no error.
  - Each data bit is sampled at CLKS_PER_BIT intervals thereafter.
  - Stop bit is sampled mid-bit:
    - stop=1: raises internal rx_valid for exactly one cycle with rx_byte.
    - stop=0: byte discarded, and if the frame FSM is not in IDLE/DONE, load_err=1 and the FSM goes to IDLE.
- Frame format: 0xA5, LEN_H, LEN_L, N data bytes (N = {LEN_H,LEN_L}), CHK, where CHK = 8-bit sum of the data bytes mod 256.
- Frame FSM states: IDLE, LEN_H, LEN_L, DATA, CHK, DONE.
  - IDLE: bytes other than 0xA5 are ignored. On 0xA5 -> LEN_H; cpu_hold=1, load_done=0, load_err=0, byte_count=0, sum=0, mem_addr=BASE_ADDR.
  - LEN_H: capture the byte -> LEN_L.
  - LEN_L: capture the byte. N=0 -> CHK, else -> DATA.
  - DATA, on each rx_valid:
    - The following cycle: mem_wdata=byte, mem_we=1 for one cycle at mem_addr.
    - Then mem_addr increments (wraps 16'hFFFF -> 16'h0000), byte_count increments, sum += byte mod 256.
    - After the Nth byte -> CHK.
  - CHK:
    - byte==sum -> DONE, with load_done=1 and cpu_hold=0 on the same cycle.
    - byte!=sum -> IDLE, load_err=1, cpu_hold stays 1.
  - DONE: CPU runs. An incoming 0xA5 restarts the load (the IDLE entry actions apply, so cpu_hold=1 the cycle after the byte). Other bytes are ignored.
- Timeout: in LEN_H/LEN_L/DATA/CHK a counter clears on every rx_valid. Reaching TIMEOUT_CLKS gives load_err=1 and -> IDLE.
- mem_we is never high in IDLE/LEN_H/LEN_L/CHK/DONE; at most one write per received data byte.
- Reset mid-frame: partial data stays in memory, the FSM restarts in IDLE, cpu_hold=1.
- Simultaneous timeout and rx_valid on the same cycle: rx_valid wins and the counter clears.

Test Plan:
- CLKS_PER_BIT=4, send A5 00 03 11 22 33 66 -> writes 11@0000, 22@0001, 33@0002, one mem_we each; byte_count=3; load_done=1, cpu_hold=0 after CHK stop bit.
- Same frame with CHK=67 -> three writes occur, load_err=1, cpu_hold=1, load_done=0; then a valid frame clears load_err and completes.
- Bytes 00 FF 5A before A5 00 00 00 -> leading bytes ignored, no mem_we, N=0 frame gives load_done=1, byte_count=0.
- BASE_ADDR=16'hFFFE, frame of 4 bytes -> writes at FFFE, FFFF, 0000, 0001 (wrap).
- Stop bit forced 0 on 2nd data byte -> load_err=1, FSM IDLE, only 1 mem_we seen; 1-cycle low glitch on rx in IDLE -> no byte, no error.
- TIMEOUT_CLKS=100, send A5 00 02 11 then silence -> load_err=1 at 100 cycles after the last rx_valid; rst_n pulse mid-DATA -> all outputs at reset values asynchronously.
